// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an internal baud counter, a one-entry
// holding register (valid/ready) and per-frame parity / stop-bit selection.
// Frames are sent start bit, DATA_W data bits LSB first, optional parity,
// then one or two stop bits. A word waiting in the holding register is
// loaded on the last cycle of the stop bit so consecutive frames have no gap.
module uart_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 87
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic              stop2,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity over the data bits only; odd parity is the inverted XOR.
    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Holding register
    logic              hold_full_r;
    logic [DATA_W-1:0] hold_data_r;
    logic              hold_par_en_r;
    logic              hold_par_odd_r;
    logic              hold_stop2_r;

    // Frame registers (copied at load, stable for the whole frame)
    logic [DATA_W-1:0] frm_data_r;
    logic              frm_par_en_r;
    logic              frm_par_bit_r;
    logic              frm_stop2_r;

    // Sequencer state
    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic              stop_cnt_r;

    logic              last_stop_s;
    logic              stop_end_s;
    logic              load_s;
    logic              xfer_s;

    assign din_ready = !hold_full_r;

    // Decode transfer, last stop period and shifter load conditions.
    always_comb begin
        last_stop_s = 1'b0;
        stop_end_s  = 1'b0;
        load_s      = 1'b0;
        xfer_s      = 1'b0;
        if (!frm_stop2_r || stop_cnt_r) begin
            last_stop_s = 1'b1;
        end else begin
            last_stop_s = 1'b0;
        end
        if ((state_r == ST_STOP) && (cnt_r == CNT_LAST) && last_stop_s) begin
            stop_end_s = 1'b1;
        end else begin
            stop_end_s = 1'b0;
        end
        if (hold_full_r && ((state_r == ST_IDLE) || stop_end_s)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        if (din_valid && !hold_full_r) begin
            xfer_s = 1'b1;
        end else begin
            xfer_s = 1'b0;
        end
    end

    // Holding register: capture on transfer, empty when the shifter loads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_full_r    <= 1'b0;
            hold_data_r    <= '0;
            hold_par_en_r  <= 1'b0;
            hold_par_odd_r <= 1'b0;
            hold_stop2_r   <= 1'b0;
        end else if (xfer_s) begin
            hold_full_r    <= 1'b1;
            hold_data_r    <= din;
            hold_par_en_r  <= par_en;
            hold_par_odd_r <= par_odd;
            hold_stop2_r   <= stop2;
        end else if (load_s) begin
            hold_full_r    <= 1'b0;
        end else begin
            hold_full_r    <= hold_full_r;
        end
    end

    // Frame sequencer: state, baud/bit/stop counters and registered tx/busy/done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            idx_r         <= '0;
            stop_cnt_r    <= 1'b0;
            tx            <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            frm_data_r    <= '0;
            frm_par_en_r  <= 1'b0;
            frm_par_bit_r <= 1'b0;
            frm_stop2_r   <= 1'b0;
        end else begin
            // done is high exactly during the last clk of the final stop bit
            done <= (state_r == ST_STOP) && last_stop_s && (cnt_r == CNT_PRE);
            if (load_s) begin
                frm_data_r    <= hold_data_r;
                frm_par_en_r  <= hold_par_en_r;
                frm_par_bit_r <= parity_bit(hold_data_r, hold_par_odd_r);
                frm_stop2_r   <= hold_stop2_r;
            end
            case (state_r)
                ST_IDLE: begin
                    cnt_r      <= '0;
                    idx_r      <= '0;
                    stop_cnt_r <= 1'b0;
                    if (load_s) begin
                        state_r <= ST_START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        tx      <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        idx_r   <= '0;
                        state_r <= ST_DATA;
                        tx      <= frm_data_r[0];
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= '0;
                        if (idx_r == IDX_LAST) begin
                            if (frm_par_en_r) begin
                                state_r <= ST_PARITY;
                                tx      <= frm_par_bit_r;
                            end else begin
                                state_r    <= ST_STOP;
                                stop_cnt_r <= 1'b0;
                                tx         <= 1'b1;
                            end
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                            tx    <= frm_data_r[idx_r + IDX_W'(1)];
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r      <= '0;
                        state_r    <= ST_STOP;
                        stop_cnt_r <= 1'b0;
                        tx         <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= '0;
                        if (last_stop_s) begin
                            stop_cnt_r <= 1'b0;
                            idx_r      <= '0;
                            if (load_s) begin
                                // next frame starts with no idle gap
                                state_r <= ST_START;
                                tx      <= 1'b0;
                                busy    <= 1'b1;
                            end else begin
                                state_r <= ST_IDLE;
                                tx      <= 1'b1;
                                busy    <= 1'b0;
                            end
                        end else begin
                            stop_cnt_r <= 1'b1;
                            tx         <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= '0;
                    idx_r      <= '0;
                    stop_cnt_r <= 1'b0;
                    tx         <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: per-clock comparison of tx/busy/done/din_ready
// against hand-built expected frame streams, with CLKS_PER_BIT=4.
module tb_uart_tx_param;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid, par_en, par_odd, stop2;
    logic       din_ready, tx, busy, done;
    logic [6:0] din7;
    logic       din_valid7, par_en7, par_odd7, stop27;
    logic       din_ready7, tx7, busy7, done7;

    int n_vec = 0;
    int n_err = 0;

    logic q_tx[$];
    logic q_busy[$];
    logic q_done[$];
    logic q_rdy[$];

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(C)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
        .tx(tx), .busy(busy), .done(done)
    );

    uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(C)) u_dut7 (
        .clk(clk), .rst(rst), .din(din7), .din_valid(din_valid7), .din_ready(din_ready7),
        .par_en(par_en7), .par_odd(par_odd7), .stop2(stop27),
        .tx(tx7), .busy(busy7), .done(done7)
    );

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_tx.delete();
        q_busy.delete();
        q_done.delete();
        q_rdy.delete();
    endtask

    task automatic add_bits(input logic b, input int nbits);
        for (int i = 0; i < nbits * C; i++) begin
            q_tx.push_back(b);
            q_busy.push_back(1'b1);
            q_done.push_back(1'b0);
            q_rdy.push_back(1'b1);
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            q_tx.push_back(1'b1);
            q_busy.push_back(1'b0);
            q_done.push_back(1'b0);
            q_rdy.push_back(1'b1);
        end
    endtask

    // Append one expected frame; pb is the hand-computed parity bit.
    task automatic add_frame(input logic [8:0] d, input int w, input logic pe,
                             input logic pb, input logic s2);
        add_bits(1'b0, 1);
        for (int i = 0; i < w; i++) add_bits(d[i], 1);
        if (pe) add_bits(pb, 1);
        add_bits(1'b1, s2 ? 2 : 1);
        q_done[q_done.size() - 1] = 1'b1;
    endtask

    // Sample {tx,busy,done,din_ready} every clk and compare to the queues.
    task automatic run_stream(input string tag, input int start, input bit sel7);
        logic [3:0] obs;
        logic [3:0] exp;
        for (int k = start; k < q_tx.size(); k++) begin
            @(negedge clk);
            obs = sel7 ? {tx7, busy7, done7, din_ready7} : {tx, busy, done, din_ready};
            exp = {q_tx[k], q_busy[k], q_done[k], q_rdy[k]};
            chk($sformatf("%s[%0d]", tag, k), {28'd0, obs}, {28'd0, exp});
        end
    endtask

    // Present one word to the 8-bit DUT for a single transfer cycle.
    task automatic send8(input string tag, input logic [7:0] d, input logic pe,
                         input logic po, input logic s2);
        din       = d;
        par_en    = pe;
        par_odd   = po;
        stop2     = s2;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        chk({tag, "_accept"}, {29'd0, tx, busy, din_ready}, 32'h4);
    endtask

    task automatic frame8(input string tag, input logic [7:0] d, input logic pe,
                          input logic po, input logic pb, input logic s2);
        clear_q();
        add_frame({1'b0, d}, 8, pe, pb, s2);
        add_idle(4);
        send8(tag, d, pe, po, s2);
        run_stream(tag, 0, 1'b0);
    endtask

    initial begin
        rst        = 1'b0;
        din        = 8'h00;
        din_valid  = 1'b0;
        par_en     = 1'b0;
        par_odd    = 1'b0;
        stop2      = 1'b0;
        din7       = 7'h00;
        din_valid7 = 1'b0;
        par_en7    = 1'b0;
        par_odd7   = 1'b0;
        stop27     = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset8", {28'd0, tx, busy, done, din_ready}, 32'h9);
        chk("reset7", {28'd0, tx7, busy7, done7, din_ready7}, 32'h9);
        rst = 1'b1;
        @(negedge clk);
        chk("idle8", {28'd0, tx, busy, done, din_ready}, 32'h9);

        // basic frames
        frame8("f55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        frame8("f07_even", 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        frame8("f07_odd", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        frame8("fA3_stop2", 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1);

        // back-to-back: 0x12 then 0x34 with din_valid held
        clear_q();
        add_frame(9'h012, 8, 1'b0, 1'b0, 1'b0);
        add_frame(9'h034, 8, 1'b0, 1'b0, 1'b0);
        add_idle(4);
        for (int k = 1; k < 40; k++) q_rdy[k] = 1'b0;
        din       = 8'h12;
        par_en    = 1'b0;
        par_odd   = 1'b0;
        stop2     = 1'b0;
        din_valid = 1'b1;
        @(negedge clk);
        chk("b2b_acc1", {31'd0, din_ready}, 32'h0);
        din = 8'h34;
        @(negedge clk);
        chk("b2b_k0", {29'd0, tx, busy, din_ready}, 32'h3);
        @(negedge clk);
        din_valid = 1'b0;
        chk("b2b_k1", {29'd0, tx, busy, din_ready}, 32'h2);
        run_stream("b2b", 2, 1'b0);

        // reset during data bit 3 of 0xF0 with a word held
        send8("rstf0", 8'hF0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k == 1) begin
                din       = 8'hAA;
                din_valid = 1'b1;
            end
            if (k == 2) begin
                din_valid = 1'b0;
                chk("rst_held", {31'd0, din_ready}, 32'h0);
            end
        end
        chk("rst_pre", {30'd0, tx, busy}, 32'h1);
        rst       = 1'b0;
        din       = 8'h55;
        din_valid = 1'b1;
        @(negedge clk);
        chk("rst_abort", {28'd0, tx, busy, done, din_ready}, 32'h9);
        rst       = 1'b1;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_lost", {29'd0, tx, busy, din_ready}, 32'h5);
        frame8("f0F_after_rst", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);

        // DATA_W=7: 0x7F with even parity
        clear_q();
        add_frame(9'h07F, 7, 1'b1, 1'b1, 1'b0);
        add_idle(4);
        din7       = 7'h7F;
        par_en7    = 1'b1;
        par_odd7   = 1'b0;
        stop27     = 1'b0;
        din_valid7 = 1'b1;
        @(negedge clk);
        din_valid7 = 1'b0;
        chk("w7_accept", {29'd0, tx7, busy7, din_ready7}, 32'h4);
        run_stream("w7", 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
